// File: rtl/seg_scan_driver.sv
// Eight-digit common-anode seven-segment scanner: seconds digit, separator and song number,
// with anti-ghost guard, frame-coherent input shadowing and a pause blink on the seconds digit.
module seg_scan_driver #(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned SCAN_HZ  = 1000,
  parameter int unsigned GUARD    = 16,
  parameter int unsigned BLINK_HZ = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sec_seg,
  input  logic [4:0] song,
  input  logic       play,
  input  logic       blank_lz,
  output logic [7:0] seg_an,
  output logic [7:0] seg_cath
);

  localparam int unsigned Div      = CLK_HZ / SCAN_HZ;
  localparam int unsigned BlinkDiv = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned ScanW    = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned BlinkW   = (BlinkDiv > 1) ? $clog2(BlinkDiv) : 1;

  localparam logic [ScanW-1:0]  ScanLast  = ScanW'(Div - 1);
  localparam logic [ScanW-1:0]  GuardLen  = ScanW'(GUARD);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BlinkDiv - 1);

  logic [ScanW-1:0]  scan_cnt_q, scan_cnt_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              phase_q, phase_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        sec_sh_q, sec_sh_d;
  logic [4:0]        song_sh_q, song_sh_d;
  logic [7:0]        seg_an_q, seg_an_d;
  logic [7:0]        seg_cath_q, seg_cath_d;

  logic       scan_tick;
  logic       frame_wrap;
  logic [4:0] tens;
  logic [4:0] ones;
  logic [7:0] pattern;

  function automatic logic [7:0] dec_pat(input logic [4:0] d);
    logic [7:0] p;
    case (d)
      5'd0:    p = 8'h3F;
      5'd1:    p = 8'h06;
      5'd2:    p = 8'h5B;
      5'd3:    p = 8'h4F;
      5'd4:    p = 8'h66;
      5'd5:    p = 8'h6D;
      5'd6:    p = 8'h7D;
      5'd7:    p = 8'h07;
      5'd8:    p = 8'h7F;
      5'd9:    p = 8'h6F;
      default: p = 8'h00;
    endcase
    return p;
  endfunction

  assign scan_tick  = (scan_cnt_q == ScanLast);
  assign frame_wrap = scan_tick && (idx_q == 3'd7);
  assign tens       = song_sh_q / 5'd10;
  assign ones       = song_sh_q % 5'd10;

  always_comb begin
    scan_cnt_d  = scan_tick ? '0 : scan_cnt_q + ScanW'(1);
    idx_d       = scan_tick ? idx_q + 3'd1 : idx_q;
    blink_cnt_d = (blink_cnt_q == BlinkLast) ? '0 : blink_cnt_q + BlinkW'(1);
    phase_d     = (blink_cnt_q == BlinkLast) ? ~phase_q : phase_q;
    // Shadows only move at the frame boundary so a frame never mixes old and new values.
    sec_sh_d    = frame_wrap ? sec_seg : sec_sh_q;
    song_sh_d   = frame_wrap ? song : song_sh_q;
  end

  always_comb begin
    pattern = 8'h00;
    case (idx_q)
      3'd0:    pattern = (!play && phase_q) ? 8'h00 : sec_sh_q;
      3'd2:    pattern = 8'h40;
      3'd6:    pattern = dec_pat(ones);
      3'd7:    pattern = (blank_lz && (tens == 5'd0)) ? 8'h00 : dec_pat(tens);
      default: pattern = 8'h00;
    endcase
  end

  always_comb begin
    if (scan_cnt_q < GuardLen) begin
      seg_an_d   = 8'hFF;
      seg_cath_d = 8'hFF;
    end else begin
      seg_an_d   = ~(8'b1 << idx_q);
      seg_cath_d = ~pattern;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q  <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      idx_q       <= 3'd0;
      sec_sh_q    <= 8'h00;
      song_sh_q   <= 5'd0;
      seg_an_q    <= 8'hFF;
      seg_cath_q  <= 8'hFF;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      idx_q       <= idx_d;
      sec_sh_q    <= sec_sh_d;
      song_sh_q   <= song_sh_d;
      seg_an_q    <= seg_an_d;
      seg_cath_q  <= seg_cath_d;
    end
  end

  assign seg_an   = seg_an_q;
  assign seg_cath = seg_cath_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: time-based reference model checked every cycle, plus literal
// expectations for decode, leading-zero blanking, frame coherence, blink and mid-frame reset.
module tb_seg_scan_driver;

  localparam int unsigned CLK_HZ   = 1000;
  localparam int unsigned SCAN_HZ  = 100;
  localparam int unsigned GUARD    = 2;
  localparam int unsigned BLINK_HZ = 5;
  localparam int DIV  = CLK_HZ / SCAN_HZ;
  localparam int BDIV = CLK_HZ / (2 * BLINK_HZ);

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sec_seg;
  logic [4:0] song;
  logic       play;
  logic       blank_lz;
  logic [7:0] seg_an;
  logic [7:0] seg_cath;

  int n_chk  = 0;
  int n_fail = 0;

  seg_scan_driver #(
    .CLK_HZ  (CLK_HZ),
    .SCAN_HZ (SCAN_HZ),
    .GUARD   (GUARD),
    .BLINK_HZ(BLINK_HZ)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sec_seg (sec_seg),
    .song    (song),
    .play    (play),
    .blank_lz(blank_lz),
    .seg_an  (seg_an),
    .seg_cath(seg_cath)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] digit_pat(input int d);
    case (d)
      0: return 8'h3F;
      1: return 8'h06;
      2: return 8'h5B;
      3: return 8'h4F;
      4: return 8'h66;
      5: return 8'h6D;
      6: return 8'h7D;
      7: return 8'h07;
      8: return 8'h7F;
      9: return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  // Reference: everything is derived from the cycle count since reset.
  int         t = 0;
  logic [7:0] m_sec = 8'h00;
  int         m_song = 0;
  logic [7:0] exp_an = 8'hFF;
  logic [7:0] exp_cath = 8'hFF;
  bit         sh_on = 1'b0;
  int         sh_idx = 0;
  bit         chk_en = 1'b0;

  always @(posedge clk) begin
    int sc, di, ph;
    logic [7:0] p;
    if (rst) begin
      t = 0; m_sec = 8'h00; m_song = 0;
      exp_an = 8'hFF; exp_cath = 8'hFF; sh_on = 1'b0;
      chk_en = 1'b1;
    end else begin
      sc = t % DIV;
      di = (t / DIV) % 8;
      ph = (t / BDIV) % 2;
      case (di)
        0: p = (!play && ph == 1) ? 8'h00 : m_sec;
        2: p = 8'h40;
        6: p = digit_pat(m_song % 10);
        7: p = (blank_lz && (m_song / 10) == 0) ? 8'h00 : digit_pat(m_song / 10);
        default: p = 8'h00;
      endcase
      if (sc < GUARD) begin
        exp_an = 8'hFF; exp_cath = 8'hFF; sh_on = 1'b0;
      end else begin
        exp_an = 8'hFF ^ (8'h01 << di); exp_cath = ~p; sh_on = 1'b1; sh_idx = di;
      end
      if (sc == DIV - 1 && di == 7) begin
        m_sec = sec_seg; m_song = int'(song);
      end
      t++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_chk++;
      if (seg_an !== exp_an || seg_cath !== exp_cath) begin
        n_fail++;
        $display("FAIL model t=%0d: an=%h cath=%h, required an=%h cath=%h",
                 t, seg_an, seg_cath, exp_an, exp_cath);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // Waits until the outputs show digit d outside the guard window.
  task automatic wait_digit(input int d);
    bit ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (sh_on && sh_idx == d) begin
        ok = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_digit%0d: not shown, required within 200 cycles", d);
    end
  endtask

  task automatic sync_frame();
    wait_digit(7);
    wait_digit(0);
  endtask

  initial begin
    bit seen_on, seen_off, seen_other;
    rst = 1'b1; sec_seg = 8'h00; song = 5'd0; play = 1'b1; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_an", seg_an, 8'hFF);
    chk("reset_cath", seg_cath, 8'hFF);

    // Digit stepping, and the first frame shows song 0 with tens unblanked.
    for (int d = 0; d < 8; d++) begin
      wait_digit(d);
      chk("step_an", seg_an, 8'hFF ^ (8'h01 << d));
    end

    song = 5'd27; blank_lz = 1'b0; play = 1'b1;
    sync_frame();
    wait_digit(2); chk("dash_cath", seg_cath, 8'hBF);
    wait_digit(6); chk("ones_an", seg_an, 8'hBF); chk("ones_cath", seg_cath, 8'hF8);
    wait_digit(7); chk("tens_an", seg_an, 8'h7F); chk("tens_cath", seg_cath, 8'hA4);

    song = 5'd5; blank_lz = 1'b1;
    sync_frame();
    wait_digit(6); chk("lz_ones", seg_cath, 8'h92);
    wait_digit(7); chk("lz_blank", seg_cath, 8'hFF);
    blank_lz = 1'b0;
    wait_digit(7); chk("lz_shown", seg_cath, 8'hC0);

    song = 5'd12;
    sync_frame();
    wait_digit(3);
    song = 5'd31;
    wait_digit(6); chk("coh_old_ones", seg_cath, 8'hA4);
    wait_digit(7); chk("coh_old_tens", seg_cath, 8'hF9);
    wait_digit(0);
    wait_digit(6); chk("coh_new_ones", seg_cath, 8'hF9);
    wait_digit(7); chk("coh_new_tens", seg_cath, 8'hB0);

    sec_seg = 8'h06; play = 1'b0;
    sync_frame();
    seen_on = 0; seen_off = 0; seen_other = 0;
    repeat (400) begin
      @(negedge clk);
      if (sh_on && sh_idx == 0) begin
        if (seg_cath == 8'hF9) seen_on = 1;
        else if (seg_cath == 8'hFF) seen_off = 1;
        else seen_other = 1;
      end
    end
    chk("blink_on_seen", {7'd0, seen_on}, 8'h01);
    chk("blink_off_seen", {7'd0, seen_off}, 8'h01);
    chk("blink_other", {7'd0, seen_other}, 8'h00);
    play = 1'b1;
    @(negedge clk);
    seen_off = 0; seen_other = 0;
    repeat (400) begin
      @(negedge clk);
      if (sh_on && sh_idx == 0 && seg_cath != 8'hF9) seen_off = 1;
    end
    chk("play_steady", {7'd0, seen_off}, 8'h00);

    wait_digit(5);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_an", seg_an, 8'hFF);
    chk("midrst_cath", seg_cath, 8'hFF);
    rst = 1'b0;
    wait_digit(0); chk("post_rst_sec", seg_cath, 8'hFF);
    wait_digit(6); chk("post_rst_ones", seg_cath, 8'hC0);
    wait_digit(7); chk("post_rst_tens", seg_cath, 8'hC0);

    // Random traffic, including occasional resets, checked by the model every cycle.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 29) == 0) sec_seg = 8'($urandom);
      if ($urandom_range(0, 29) == 0) song = 5'($urandom);
      if ($urandom_range(0, 99) == 0) play = ~play;
      if ($urandom_range(0, 99) == 0) blank_lz = ~blank_lz;
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
